instruction_fetch_unit: RTL and testbench

//  Producer end of the instruction interface the decode_unit consumes: owns the PC, issues

---
 rtl/instruction_fetch_unit_pkg.sv | 19 +
 rtl/instruction_fetch_unit_if.sv | 29 ++
 rtl/instruction_fetch_unit_fetch_fifo.sv | 76 +++++++
 rtl/instruction_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One buffered fetch result: the instruction word and where it came from.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Sequential next word address; wraps naturally at the top of the address space.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/response, execute redirect, decode handshake.
interface instruction_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );

  // Environment side: instruction memory, execute and decode.
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );
endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Shift-style instruction buffer: entry 0 is always the head, so the head is a register.
module fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_data,
  output fetch_entry_t  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, pc: 32'h0000_0000};

  fetch_entry_t  r_mem [DEPTH];
  fetch_entry_t  w_mem_next [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          w_push;
  logic          w_pop;
  int            w_wr_idx;

  // Next buffer contents: shift down on pop, write behind the last valid entry on push.
  always_comb begin
    w_pop        = i_pop && (r_count != '0);
    w_push       = i_push && ((r_count != CW'(DEPTH)) || w_pop);
    w_wr_idx     = w_pop ? (int'(r_count) - 1) : int'(r_count);
    w_count_next = r_count;
    for (int i = 0; i < DEPTH; i++) w_mem_next[i] = r_mem[i];
    if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) w_mem_next[i] = EMPTY_ENTRY;
      w_count_next = '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) w_mem_next[i] = r_mem[i + 1];
        w_mem_next[DEPTH-1] = EMPTY_ENTRY;
      end else begin
        w_count_next = r_count;
      end
      if (w_push) begin
        for (int i = 0; i < DEPTH; i++) w_mem_next[i] = (i == w_wr_idx) ? i_data : w_mem_next[i];
      end else begin
        w_count_next = r_count;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + CW'(1);
        2'b01:   w_count_next = r_count - CW'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  // Buffer storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= EMPTY_ENTRY;
      r_count <= '0;
    end else begin
      r_mem   <= w_mem_next;
      r_count <= w_count_next;
    end
  end

  assign o_head  = r_mem[0];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited word reads, buffers responses for
// decode, and handles redirects (including misaligned targets, which halt fetch).
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  instruction_fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic            r_fault;
  logic            r_req_valid;

  logic            w_fire;
  logic            w_rsp;
  logic            w_redirect;
  logic            w_misaligned;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic [CW-1:0]   w_fifo_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;
  logic [CW-1:0]   w_out_next;
  logic [CW-1:0]   w_fifo_cnt_next;
  logic [CW:0]     w_credit_used;
  logic            w_fault_next;
  logic            w_req_valid_next;

  assign w_fire       = r_req_valid & bus.imem_req_ready;
  assign w_rsp        = bus.imem_rsp_valid;
  assign w_redirect   = bus.redirect_valid;
  assign w_misaligned = (bus.redirect_pc[1:0] != 2'b00);
  assign w_pop        = !w_fifo_empty & bus.instr_ready;
  // Responses belonging to squashed requests are counted off by drop_cnt and never pushed.
  assign w_push       = w_rsp & !w_redirect & (r_drop_cnt == '0) & (!w_fifo_full | w_pop);
  assign w_push_data  = '{instr: bus.imem_rsp_data, pc: r_rsp_pc};

  // Next-state credit and fault terms; request valid is registered from the next state.
  always_comb begin
    w_out_next = r_outstanding + CW'(w_fire) - CW'(w_rsp);
    if (w_redirect) begin
      w_fifo_cnt_next = '0;
      w_fault_next    = w_misaligned;
    end else begin
      w_fifo_cnt_next = w_fifo_count + CW'(w_push) - CW'(w_pop);
      w_fault_next    = r_fault;
    end
    w_credit_used    = (CW+1)'(w_out_next) + (CW+1)'(w_fifo_cnt_next);
    w_req_valid_next = !w_fault_next && (w_credit_used < (CW+1)'(FIFO_DEPTH));
  end

  // Credit, drop and fault bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_fault       <= 1'b0;
      r_req_valid   <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      r_fault       <= w_fault_next;
      r_req_valid   <= w_req_valid_next;
      if (w_redirect) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_drop_cnt <= w_out_next;
      end else if (w_rsp && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
    end
  end

  // Request PC and the PC tag of the next response to be buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc     <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      r_rsp_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      if (w_fire) r_pc <= pc_next(r_pc);
      else        r_pc <= r_pc;
      if (w_push) r_rsp_pc <= pc_next(r_rsp_pc);
      else        r_rsp_pc <= r_rsp_pc;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.imem_req_valid = r_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.instr_valid    = !w_fifo_empty;
  assign bus.instruction    = w_head.instr;
  assign bus.instr_pc       = w_head.pc;
  assign bus.fetch_fault    = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus randomized traffic against
// a queue-based model of requests in flight and buffered instructions.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus0();
  instruction_fetch_unit_if bus1();

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  // Model: PC, fault, requests in flight (with stale marks), buffered instruction PCs.
  logic [31:0] m_pc;
  bit          m_fault;
  bit          m_fresh;
  logic [31:0] m_inf_addr[$];
  bit          m_inf_stale[$];
  logic [31:0] m_buf[$];
  logic [31:0] mq[$];

  int          cyc;
  logic [31:0] fire_addr[$];
  int          fire_cyc[$];
  int          first_valid_cyc;
  logic [31:0] first_valid_pc;
  bit          seek, seek_got;
  logic [31:0] seek_pc;
  bit          last_dfire, last_rsp;
  logic [31:0] log1[$];
  logic [31:0] p1[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  function automatic bit exp_rv();
    return !m_fresh && !m_fault && ((m_inf_addr.size() + m_buf.size()) < DEPTH);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_0000;
    m_fault = 1'b0;
    m_fresh = 1'b1;
    m_inf_addr.delete();
    m_inf_stale.delete();
    m_buf.delete();
    mq.delete();
  endtask

  task automatic idle_inputs();
    bus0.imem_req_ready = 1'b0;
    bus0.imem_rsp_valid = 1'b0;
    bus0.imem_rsp_data  = 32'h0000_0000;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_pc    = 32'h0000_0000;
    bus0.instr_ready    = 1'b0;
  endtask

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("req_valid", 32'(bus0.imem_req_valid), 32'(exp_rv()));
      if (exp_rv()) check("req_addr", bus0.imem_req_addr, m_pc);
      check("instr_valid", 32'(bus0.instr_valid), 32'(m_buf.size() > 0));
      check("fetch_fault", 32'(bus0.fetch_fault), 32'(m_fault));
      if (m_buf.size() > 0) begin
        check("instr_pc", bus0.instr_pc, m_buf[0]);
        check("instruction", bus0.instruction, memf(m_buf[0]));
      end
    end
  end

  // One clock of stimulus: drive inputs, run memory, advance the model.
  task automatic do_cycle(input int p_req, input int p_rsp, input int p_ir,
                          input bit redir, input logic [31:0] rpc);
    bit rdy, rsp, ird, dfire, mfire, mpop, st;
    logic [31:0] a;
    @(negedge clk);
    #1;
    cyc++;
    if (bus0.instr_valid && first_valid_cyc < 0) begin
      first_valid_cyc = cyc;
      first_valid_pc  = bus0.instr_pc;
    end
    if (seek && bus0.instr_valid) begin
      seek = 1'b0;
      seek_got = 1'b1;
      seek_pc = bus0.instr_pc;
    end
    rdy = ($urandom_range(99) < p_req);
    rsp = (mq.size() > 0) && ($urandom_range(99) < p_rsp);
    ird = ($urandom_range(99) < p_ir);
    bus0.imem_req_ready = rdy;
    bus0.imem_rsp_valid = rsp;
    bus0.imem_rsp_data  = rsp ? memf(mq[0]) : $urandom;
    bus0.instr_ready    = ird;
    bus0.redirect_valid = redir;
    bus0.redirect_pc    = redir ? rpc : $urandom;
    dfire = bus0.imem_req_valid && rdy;
    last_dfire = dfire;
    last_rsp = rsp;
    if (rsp) void'(mq.pop_front());
    if (dfire) begin
      mq.push_back(bus0.imem_req_addr);
      fire_addr.push_back(bus0.imem_req_addr);
      fire_cyc.push_back(cyc);
    end
    mfire = exp_rv() && rdy;
    mpop  = (m_buf.size() > 0) && ird;
    if (mpop) void'(m_buf.pop_front());
    if (rsp && m_inf_addr.size() > 0) begin
      a  = m_inf_addr.pop_front();
      st = m_inf_stale.pop_front();
      if (!redir && !st) m_buf.push_back(a);
    end
    if (mfire) begin
      m_inf_addr.push_back(m_pc);
      m_inf_stale.push_back(1'b0);
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      foreach (m_inf_stale[i]) m_inf_stale[i] = 1'b1;
      m_buf.delete();
      m_pc = rpc;
      m_fault = (rpc[1:0] != 2'b00);
      seek = 1'b1;
      seek_got = 1'b0;
    end
    m_fresh = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    m_fresh = 1'b0;
  endtask

  // Second instance: 1-cycle memory, decode always ready, logs its first request addresses.
  initial begin
    bus1.imem_req_ready = 1'b1;
    bus1.imem_rsp_valid = 1'b0;
    bus1.imem_rsp_data  = 32'h0000_0000;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc    = 32'h0000_0000;
    bus1.instr_ready    = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        p1.delete();
        bus1.imem_rsp_valid = 1'b0;
      end else begin
        bus1.imem_rsp_valid = (p1.size() > 0);
        bus1.imem_rsp_data  = (p1.size() > 0) ? memf(p1.pop_front()) : 32'h0000_0000;
        if (bus1.imem_req_valid) begin
          p1.push_back(bus1.imem_req_addr);
          if (log1.size() < 3) log1.push_back(bus1.imem_req_addr);
        end
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    int r, pr, ps, pi;
    idle_inputs();
    model_reset();
    cyc = 0;
    first_valid_cyc = -1;
    seek = 1'b0;
    seek_got = 1'b0;
    chk_on = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_valid", 32'(bus0.imem_req_valid), 32'd0);
    check("rst_req_addr", bus0.imem_req_addr, 32'h0000_0000);
    check("rst_instr_valid", 32'(bus0.instr_valid), 32'd0);
    check("rst_instruction", bus0.instruction, 32'h0000_0013);
    check("rst_instr_pc", bus0.instr_pc, 32'h0000_0000);
    check("rst_fault", 32'(bus0.fetch_fault), 32'd0);
    check("rst_addr_dut1", bus1.imem_req_addr, 32'hFFFF_FFF8);
    rst_n = 1'b1;
    m_fresh = 1'b0;

    // 1: streaming with 1-cycle memory and decode always ready
    repeat (10) do_cycle(100, 100, 100, 1'b0, 32'h0);
    check("t1_addr0", (fire_addr.size() > 0) ? fire_addr[0] : 32'hDEAD_BEEF, 32'h0000_0000);
    check("t1_addr1", (fire_addr.size() > 1) ? fire_addr[1] : 32'hDEAD_BEEF, 32'h0000_0004);
    check("t1_addr2", (fire_addr.size() > 2) ? fire_addr[2] : 32'hDEAD_BEEF, 32'h0000_0008);
    check("t1_latency", (fire_cyc.size() > 0) ? 32'(first_valid_cyc - fire_cyc[0]) : 32'hDEAD_BEEF,
          32'd2);
    check("t1_first_pc", first_valid_pc, 32'h0000_0000);

    // 2: decode stalls, buffer fills, requests stop
    repeat (6) do_cycle(100, 100, 0, 1'b0, 32'h0);
    check("t2_valid_held", 32'(bus0.instr_valid), 32'd1);
    check("t2_req_stalled", 32'(bus0.imem_req_valid), 32'd0);
    repeat (8) do_cycle(100, 100, 100, 1'b0, 32'h0);

    // 3: redirect with two requests outstanding
    repeat (4) do_cycle(100, 0, 100, 1'b0, 32'h0);
    check("t3_outstanding", 32'(mq.size()), 32'd2);
    do_cycle(0, 0, 100, 1'b1, 32'h0000_0100);
    repeat (12) do_cycle(100, 100, 100, 1'b0, 32'h0);
    check("t3_resume_seen", 32'(seek_got), 32'd1);
    check("t3_resume_pc", seek_pc, 32'h0000_0100);

    // 4: redirect coincident with request fire and response
    do_reset();
    do_cycle(100, 0, 100, 1'b0, 32'h0);
    do_cycle(100, 100, 100, 1'b1, 32'h0000_0300);
    check("t4_fire_in_R", 32'(last_dfire), 32'd1);
    check("t4_rsp_in_R", 32'(last_rsp), 32'd1);
    repeat (12) do_cycle(100, 100, 100, 1'b0, 32'h0);
    check("t4_resume_pc", seek_pc, 32'h0000_0300);

    // 5: misaligned redirect halts; aligned redirect restarts
    do_cycle(100, 100, 100, 1'b1, 32'h0000_0102);
    repeat (5) do_cycle(100, 100, 100, 1'b0, 32'h0);
    check("t5_fault_set", 32'(bus0.fetch_fault), 32'd1);
    check("t5_no_req", 32'(bus0.imem_req_valid), 32'd0);
    do_cycle(100, 100, 100, 1'b1, 32'h0000_0200);
    @(posedge clk);
    #1;
    check("t5_fault_clr", 32'(bus0.fetch_fault), 32'd0);
    check("t5_restart_addr", bus0.imem_req_addr, 32'h0000_0200);
    check("t5_restart_req", 32'(bus0.imem_req_valid), 32'd1);
    repeat (10) do_cycle(100, 100, 100, 1'b0, 32'h0);

    // 6: reset PC near the top of memory wraps; async reset mid-stream
    check("t6_wrap0", (log1.size() > 0) ? log1[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    check("t6_wrap1", (log1.size() > 1) ? log1[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("t6_wrap2", (log1.size() > 2) ? log1[2] : 32'hDEAD_BEEF, 32'h0000_0000);
    repeat (5) do_cycle(100, 100, 100, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check("t6_arst_req_valid", 32'(bus0.imem_req_valid), 32'd0);
    check("t6_arst_addr", bus0.imem_req_addr, 32'h0000_0000);
    check("t6_arst_instr_valid", 32'(bus0.instr_valid), 32'd0);
    check("t6_arst_instruction", bus0.instruction, 32'h0000_0013);
    check("t6_arst_instr_pc", bus0.instr_pc, 32'h0000_0000);
    check("t6_arst_addr_dut1", bus1.imem_req_addr, 32'hFFFF_FFF8);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    m_fresh = 1'b0;

    // Randomized traffic with occasional redirects (some misaligned, some near the wrap)
    for (int seg = 0; seg < 30; seg++) begin
      pr = $urandom_range(30, 100);
      ps = $urandom_range(20, 100);
      pi = $urandom_range(10, 100);
      for (int k = 0; k < 100; k++) begin
        if ($urandom_range(99) < 4) begin
          r = $urandom_range(9);
          rpc = $urandom;
          rpc[1:0] = 2'b00;
          if (r == 0) rpc[1:0] = 2'(($urandom_range(2)) + 1);
          else if (r == 1) rpc = 32'hFFFF_FFF0;
          do_cycle(pr, ps, pi, 1'b1, rpc);
        end else begin
          do_cycle(pr, ps, pi, 1'b0, 32'h0);
        end
      end
    end

    @(negedge clk);
    #1;
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
